// File: rtl/msk_burst_sched.sv
// ---------------------------------------------------------------------------
// msk_burst_sched
//
// Burst scheduler for the MSK transmit phase stage. Payload words arrive from
// the framer over a valid/ready handshake. Each word produces one RF-on pulse
// of ON_CLKS clocks followed by an RF-off gap of OFF_CLKS clocks. During the
// pulse the word is serialised MSB first as 16 I/Q bit pairs, and each pair is
// held for CHIP_CLKS clocks. A burst repeats this for burst_len pulses.
// ON_CLKS must equal 16*CHIP_CLKS so that the last pair ends with the pulse.
//
// Ports
//   clk_msk_in      : 50 MHz MSK clock, rising edge
//   logic_rst_n     : asynchronous active-low reset
//   burst_start     : single-cycle burst request (ignored while busy)
//   burst_len       : pulses per burst, sampled on an accepted start
//   burst_abort     : forces IDLE; no burst_done is issued
//   word_data       : payload word, bit 31 sent first
//   word_valid      : word_data is valid
//   word_ready      : combinational; the word is consumed on valid & ready
//   phase_pulse_out : RF-on gate
//   phase_i_out     : current I bit (0 outside the pulse)
//   phase_q_out     : current Q bit (0 outside the pulse)
//   busy            : high when not IDLE
//   burst_done      : one-cycle pulse at the end of a burst
//   underflow       : sticky; a word was missing when one was due
//   pulse_cnt       : pulses completed in the current or last burst
// ---------------------------------------------------------------------------
module msk_burst_sched #(
   parameter int ON_CLKS   = 320,
   parameter int OFF_CLKS  = 330,
   parameter int CHIP_CLKS = 20
) (
   input  logic        clk_msk_in,
   input  logic        logic_rst_n,
   input  logic        burst_start,
   input  logic [7:0]  burst_len,
   input  logic        burst_abort,
   input  logic [31:0] word_data,
   input  logic        word_valid,
   output logic        word_ready,
   output logic        phase_pulse_out,
   output logic        phase_i_out,
   output logic        phase_q_out,
   output logic        busy,
   output logic        burst_done,
   output logic        underflow,
   output logic [7:0]  pulse_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   localparam logic [8:0] ON_LAST   = 9'(ON_CLKS - 1);
   localparam logic [8:0] OFF_LAST  = 9'(OFF_CLKS - 1);
   localparam logic [4:0] CHIP_LAST = 5'(CHIP_CLKS - 1);

   state_t      state_reg, state_next;
   logic [8:0]  slot_cnt_reg, slot_cnt_next;
   logic [4:0]  chip_cnt_reg, chip_cnt_next;
   logic [7:0]  remaining_reg, remaining_next;
   // Pairs still to be sent; the top two bits are the next pair.
   logic [29:0] shift_reg, shift_next;
   logic        pulse_reg, pulse_next;
   logic        i_reg, i_next;
   logic        q_reg, q_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        underflow_reg, underflow_next;
   logic [7:0]  pulse_cnt_reg, pulse_cnt_next;

   logic        idle_accept;
   logic        off_reload;

   // A start is only taken from IDLE with a non-zero length and a word in hand.
   assign idle_accept = (state_reg == IDLE) && burst_start && (burst_len != 8'd0)
                        && word_valid && !burst_abort;
   // Next word of an ongoing burst is fetched on the last OFF clock only.
   assign off_reload  = (state_reg == OFF) && (slot_cnt_reg == OFF_LAST)
                        && (remaining_reg != 8'd0) && word_valid && !burst_abort;

   assign word_ready = idle_accept || off_reload;

   always_comb begin
      state_next     = state_reg;
      slot_cnt_next  = slot_cnt_reg;
      chip_cnt_next  = chip_cnt_reg;
      remaining_next = remaining_reg;
      shift_next     = shift_reg;
      pulse_next     = pulse_reg;
      i_next         = i_reg;
      q_next         = q_reg;
      done_next      = 1'b0;
      underflow_next = underflow_reg;
      pulse_cnt_next = pulse_cnt_reg;

      if (burst_abort) begin
         state_next    = IDLE;
         slot_cnt_next = 9'd0;
         chip_cnt_next = 5'd0;
         pulse_next    = 1'b0;
         i_next        = 1'b0;
         q_next        = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (idle_accept) begin
                  remaining_next = burst_len - 8'd1;
                  pulse_cnt_next = 8'd0;
                  underflow_next = 1'b0;
               end
            end
            ON: begin
               if (slot_cnt_reg == ON_LAST) begin
                  state_next     = OFF;
                  slot_cnt_next  = 9'd0;
                  pulse_next     = 1'b0;
                  i_next         = 1'b0;
                  q_next         = 1'b0;
                  // Only burst_len = 255 can reach 255, so saturation never
                  // hides a real count.
                  pulse_cnt_next = (pulse_cnt_reg == 8'hFF) ? 8'hFF
                                                            : pulse_cnt_reg + 8'd1;
               end else begin
                  slot_cnt_next = slot_cnt_reg + 9'd1;
                  if (chip_cnt_reg == CHIP_LAST) begin
                     chip_cnt_next = 5'd0;
                     i_next        = shift_reg[29];
                     q_next        = shift_reg[28];
                     shift_next    = {shift_reg[27:0], 2'b00};
                  end else begin
                     chip_cnt_next = chip_cnt_reg + 5'd1;
                  end
               end
            end
            OFF: begin
               if (slot_cnt_reg == OFF_LAST) begin
                  if (remaining_reg == 8'd0) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end else if (word_valid) begin
                     remaining_next = remaining_reg - 8'd1;
                  end else begin
                     state_next     = IDLE;
                     done_next      = 1'b1;
                     underflow_next = 1'b1;
                  end
               end else begin
                  slot_cnt_next = slot_cnt_reg + 9'd1;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase

         // Common word load: the first pair is presented on the next clock.
         if (word_ready) begin
            state_next    = ON;
            slot_cnt_next = 9'd0;
            chip_cnt_next = 5'd0;
            pulse_next    = 1'b1;
            i_next        = word_data[31];
            q_next        = word_data[30];
            shift_next    = word_data[29:0];
         end
      end

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk_msk_in or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         state_reg     <= IDLE;
         slot_cnt_reg  <= 9'd0;
         chip_cnt_reg  <= 5'd0;
         remaining_reg <= 8'd0;
         shift_reg     <= 30'd0;
         pulse_reg     <= 1'b0;
         i_reg         <= 1'b0;
         q_reg         <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         underflow_reg <= 1'b0;
         pulse_cnt_reg <= 8'd0;
      end else begin
         state_reg     <= state_next;
         slot_cnt_reg  <= slot_cnt_next;
         chip_cnt_reg  <= chip_cnt_next;
         remaining_reg <= remaining_next;
         shift_reg     <= shift_next;
         pulse_reg     <= pulse_next;
         i_reg         <= i_next;
         q_reg         <= q_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         underflow_reg <= underflow_next;
         pulse_cnt_reg <= pulse_cnt_next;
      end
   end

   assign phase_pulse_out = pulse_reg;
   assign phase_i_out     = i_reg;
   assign phase_q_out     = q_reg;
   assign busy            = busy_reg;
   assign burst_done      = done_reg;
   assign underflow       = underflow_reg;
   assign pulse_cnt       = pulse_cnt_reg;

endmodule

// File: tb/tb_msk_burst_sched.sv
// ---------------------------------------------------------------------------
// tb_msk_burst_sched
//
// Scoreboard bench for msk_burst_sched. The stimulus pushes the expected
// pulses (word, length, period check) and burst completions (pulse_cnt,
// underflow) into queues; an independent monitor rebuilds each pulse from
// the I/Q streams and pops/compares on every pulse end and every burst_done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msk_burst_sched;

   logic        clk_msk_in = 1'b0;
   logic        logic_rst_n = 1'b0;
   logic        burst_start = 1'b0;
   logic [7:0]  burst_len = 8'd0;
   logic        burst_abort = 1'b0;
   logic [31:0] word_data = 32'd0;
   logic        word_valid = 1'b0;
   logic        word_ready;
   logic        phase_pulse_out;
   logic        phase_i_out;
   logic        phase_q_out;
   logic        busy;
   logic        burst_done;
   logic        underflow;
   logic [7:0]  pulse_cnt;

   msk_burst_sched #(
      .ON_CLKS  (320),
      .OFF_CLKS (330),
      .CHIP_CLKS(20)
   ) dut (
      .clk_msk_in     (clk_msk_in),
      .logic_rst_n    (logic_rst_n),
      .burst_start    (burst_start),
      .burst_len      (burst_len),
      .burst_abort    (burst_abort),
      .word_data      (word_data),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
      .phase_pulse_out(phase_pulse_out),
      .phase_i_out    (phase_i_out),
      .phase_q_out    (phase_q_out),
      .busy           (busy),
      .burst_done     (burst_done),
      .underflow      (underflow),
      .pulse_cnt      (pulse_cnt)
   );

   always #10 clk_msk_in = ~clk_msk_in;

   int cyc = 0;
   always @(posedge clk_msk_in) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] word;
      int          len;
      bit          chk_period;
   } pulse_exp_t;

   typedef struct {
      int cnt;
      bit uf;
   } done_exp_t;

   pulse_exp_t pulse_q[$];
   done_exp_t  done_q[$];

   // ---------------- monitor ----------------
   bit          prev_pulse = 0;
   bit          have_rise = 0;
   int          on_len = 0;
   int          last_rise = 0;
   int          cur_period = -1;
   int          fall_cyc = 0;
   int          iq_off_err = 0;
   logic [31:0] w_first = '0;
   logic [31:0] w_last = '0;

   always @(negedge clk_msk_in) begin
      pulse_exp_t pe;
      done_exp_t  de;
      int         k;
      if (!logic_rst_n) begin
         prev_pulse = 0;
         have_rise  = 0;
         on_len     = 0;
      end else begin
         if (phase_pulse_out) begin
            if (!prev_pulse) begin
               cur_period = have_rise ? (cyc - last_rise) : -1;
               last_rise  = cyc;
               have_rise  = 1;
               on_len     = 0;
               w_first    = '0;
               w_last     = '0;
            end
            if (on_len < 320) begin
               k = on_len / 20;
               if (on_len % 20 == 0) begin
                  w_first[31 - 2*k] = phase_i_out;
                  w_first[30 - 2*k] = phase_q_out;
               end
               if (on_len % 20 == 19) begin
                  w_last[31 - 2*k] = phase_i_out;
                  w_last[30 - 2*k] = phase_q_out;
               end
            end
            on_len++;
         end else if (prev_pulse) begin
            fall_cyc = cyc;
            if (pulse_q.size() == 0) begin
               check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
               pe = pulse_q.pop_front();
               $display("[TB] pulse end: len=%0d word=0x%08h period=%0d", on_len, w_first, cur_period);
               check("pulse_len", 32'(on_len), 32'(pe.len));
               if (pe.len == 320) begin
                  check("iq_chip_start", w_first, pe.word);
                  check("iq_chip_end", w_last, pe.word);
               end
               if (pe.chk_period) check("pulse_period", 32'(cur_period), 32'd650);
            end
         end
         if (!phase_pulse_out && (phase_i_out || phase_q_out)) iq_off_err++;
         if (burst_done) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               de = done_q.pop_front();
               $display("[TB] burst done: pulse_cnt=%0d underflow=%0b", pulse_cnt, underflow);
               check("done_pulse_cnt", 32'(pulse_cnt), 32'(de.cnt));
               check("done_underflow", 32'(underflow), 32'(de.uf));
               check("done_busy_low", 32'(busy), 32'd0);
               check("done_gap", 32'(cyc - fall_cyc), 32'd330);
            end
         end
         if (!busy) have_rise = 0;
         prev_pulse = phase_pulse_out;
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] wlist [8];
   int          hs_cnt = 0;

   // Starts a burst on the current cycle and feeds words until the DUT
   // returns to IDLE. end_c is the clock count from the start cycle.
   task automatic run_burst(input logic [7:0] len, input int nwords, input int abort_at,
                            input int busy_start_at, output int end_c);
      int idx = 0;
      int c = 0;
      bit seen_busy = 0;
      bit hs;
      hs_cnt      = 0;
      burst_start = 1'b1;
      burst_len   = len;
      word_valid  = (nwords > 0);
      word_data   = wlist[0];
      forever begin
         @(negedge clk_msk_in);
         hs = word_valid && word_ready;
         if (busy) seen_busy = 1;
         if (seen_busy && !busy) break;
         if (c > 5000) begin
            check("burst_timeout", 32'd1, 32'd0);
            break;
         end
         @(posedge clk_msk_in);
         #1;
         c++;
         burst_start = (c == busy_start_at);
         burst_len   = (c == busy_start_at) ? 8'd7 : len;
         if (hs) begin
            hs_cnt++;
            idx++;
         end
         word_valid  = (idx < nwords);
         word_data   = wlist[(idx < 8) ? idx : 0];
         burst_abort = (c == abort_at);
      end
      burst_start = 1'b0;
      burst_abort = 1'b0;
      word_valid  = 1'b0;
      end_c       = c;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "global timeout");
   end

   initial begin
      int end_c;
      int err;

      repeat (3) @(posedge clk_msk_in);
      @(negedge clk_msk_in);
      check("reset_outputs",
            32'({phase_pulse_out, phase_i_out, phase_q_out, busy, burst_done, underflow, word_ready}),
            32'd0);
      check("reset_pulse_cnt", 32'(pulse_cnt), 32'd0);
      @(posedge clk_msk_in);
      #1 logic_rst_n = 1'b1;

      err = 0;
      repeat (100) begin
         @(negedge clk_msk_in);
         if (phase_pulse_out || phase_i_out || phase_q_out || busy || burst_done
             || underflow || word_ready || (pulse_cnt != 8'd0)) err++;
      end
      check("idle_quiet", 32'(err), 32'd0);
      $display("[TB] idle after reset: %0d bad cycles", err);

      // Single pulse burst
      @(posedge clk_msk_in); #1;
      wlist[0] = 32'hA5A5_F00F;
      pulse_q.push_back('{32'hA5A5_F00F, 320, 1'b0});
      done_q.push_back('{1, 1'b0});
      run_burst(8'd1, 1, -1, -1, end_c);
      $display("[TB] burst len=1: end=%0d handshakes=%0d", end_c, hs_cnt);
      check("t1_duration", 32'(end_c), 32'd651);
      check("t1_handshakes", 32'(hs_cnt), 32'd1);

      // Three pulses, words always valid, plus a start while busy
      @(posedge clk_msk_in); #1;
      wlist[0] = 32'h1234_5678; wlist[1] = 32'hDEAD_BEEF; wlist[2] = 32'h0F0F_3C3C;
      pulse_q.push_back('{32'h1234_5678, 320, 1'b0});
      pulse_q.push_back('{32'hDEAD_BEEF, 320, 1'b1});
      pulse_q.push_back('{32'h0F0F_3C3C, 320, 1'b1});
      done_q.push_back('{3, 1'b0});
      run_burst(8'd3, 3, -1, 100, end_c);
      $display("[TB] burst len=3: end=%0d handshakes=%0d", end_c, hs_cnt);
      check("t3_duration", 32'(end_c), 32'd1951);
      check("t3_handshakes", 32'(hs_cnt), 32'd3);

      // Underflow: four pulses requested, only two words supplied
      @(posedge clk_msk_in); #1;
      wlist[0] = 32'hFFFF_0000; wlist[1] = 32'h8000_0001;
      pulse_q.push_back('{32'hFFFF_0000, 320, 1'b0});
      pulse_q.push_back('{32'h8000_0001, 320, 1'b1});
      done_q.push_back('{2, 1'b1});
      run_burst(8'd4, 2, -1, -1, end_c);
      $display("[TB] burst len=4 underflow: end=%0d handshakes=%0d", end_c, hs_cnt);
      check("uf_duration", 32'(end_c), 32'd1301);
      check("uf_handshakes", 32'(hs_cnt), 32'd2);
      repeat (10) @(negedge clk_msk_in);
      check("uf_sticky", 32'(underflow), 32'd1);

      // Next accepted start clears underflow
      @(posedge clk_msk_in); #1;
      wlist[0] = 32'h55AA_33CC;
      pulse_q.push_back('{32'h55AA_33CC, 320, 1'b0});
      done_q.push_back('{1, 1'b0});
      run_burst(8'd1, 1, -1, -1, end_c);
      $display("[TB] burst len=1 after underflow: end=%0d", end_c);
      check("clr_duration", 32'(end_c), 32'd651);

      // Abort at clock 150 of pulse 2 of 5
      @(posedge clk_msk_in); #1;
      wlist[0] = 32'h1111_1111; wlist[1] = 32'h2222_2222; wlist[2] = 32'h3333_3333;
      wlist[3] = 32'h4444_4444; wlist[4] = 32'h5555_5555;
      pulse_q.push_back('{32'h1111_1111, 320, 1'b0});
      pulse_q.push_back('{32'h2222_2222, 150, 1'b1});
      run_burst(8'd5, 5, 800, -1, end_c);
      $display("[TB] burst len=5 abort: end=%0d handshakes=%0d pulse_cnt=%0d", end_c, hs_cnt, pulse_cnt);
      check("abort_stop_cycle", 32'(end_c), 32'd801);
      check("abort_handshakes", 32'(hs_cnt), 32'd2);
      check("abort_pulse_cnt", 32'(pulse_cnt), 32'd1);
      check("abort_outputs",
            32'({phase_pulse_out, phase_i_out, phase_q_out, busy, burst_done}), 32'd0);
      repeat (20) @(negedge clk_msk_in);

      // Ignored starts: zero length, and no word available
      @(posedge clk_msk_in); #1;
      burst_start = 1'b1; burst_len = 8'd0; word_valid = 1'b1; word_data = 32'hCAFE_F00D;
      @(negedge clk_msk_in);
      check("len0_ready", 32'(word_ready), 32'd0);
      @(posedge clk_msk_in); #1;
      burst_len = 8'd3; word_valid = 1'b0;
      @(negedge clk_msk_in);
      check("novalid_ready", 32'(word_ready), 32'd0);
      @(posedge clk_msk_in); #1;
      burst_start = 1'b0;
      err = 0;
      repeat (10) begin
         @(negedge clk_msk_in);
         if (busy || phase_pulse_out || burst_done) err++;
      end
      $display("[TB] ignored starts: %0d active cycles", err);
      check("ignored_start_idle", 32'(err), 32'd0);
      check("ignored_pulse_cnt", 32'(pulse_cnt), 32'd1);

      check("pulse_queue_empty", 32'(pulse_q.size()), 32'd0);
      check("done_queue_empty", 32'(done_q.size()), 32'd0);
      check("iq_zero_when_off", 32'(iq_off_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
